// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: decode/execute operand info, memory and branch
// status from the datapath, and the pipeline register enables and
// performance counters returned by the controller.
//
// Request/response semantics: dmem_req is held high by the MEM stage for
// as long as a data access is outstanding, and dmem_resp pulses high in the
// cycle the access completes. A cycle with dmem_req=1 and dmem_resp=0 is a
// stall cycle. imem_resp=1 means the fetch presented this cycle is valid.
// Nothing is registered on the bus, so every signal is sampled on the
// rising clk edge in the cycle it is driven.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // Decode/execute operand info.
  logic [2:0]       if_id_sr1;
  logic [2:0]       if_id_sr2;
  logic             if_id_use_sr1;
  logic             if_id_use_sr2;
  logic [2:0]       id_ex_dr;
  logic             id_ex_in_ld;

  // Memory and control-transfer status.
  logic             imem_resp;
  logic             dmem_req;
  logic             dmem_resp;
  logic             br_taken;

  // Pipeline control.
  logic             load_pc;
  logic             pc_sel_target;
  logic             load_if_id;
  logic             load_id_ex;
  logic             load_ex_mem;
  logic             load_mem_wb;
  logic             bubble_id_ex;
  logic             flush;

  // Performance counters.
  logic [CNT_W-1:0] lu_stall_cnt;
  logic [CNT_W-1:0] mem_stall_cnt;

  // Datapath side.
  modport master (
    output if_id_sr1, if_id_sr2, if_id_use_sr1, if_id_use_sr2,
    output id_ex_dr, id_ex_in_ld, imem_resp, dmem_req, dmem_resp, br_taken,
    input  load_pc, pc_sel_target, load_if_id, load_id_ex, load_ex_mem,
    input  load_mem_wb, bubble_id_ex, flush, lu_stall_cnt, mem_stall_cnt
  );

  // Controller side.
  modport slave (
    input  if_id_sr1, if_id_sr2, if_id_use_sr1, if_id_use_sr2,
    input  id_ex_dr, id_ex_in_ld, imem_resp, dmem_req, dmem_resp, br_taken,
    output load_pc, pc_sel_target, load_if_id, load_id_ex, load_ex_mem,
    output load_mem_wb, bubble_id_ex, flush, lu_stall_cnt, mem_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory freeze, branch redirect
// (flush, drain an in-flight fetch, redirect the PC), load-use bubbles and
// fetch-stall bubbles.
//
// Optional feature macro: HAZARD_CTRL_PERF_EN builds the saturating
// load-use and memory-stall counters. When it is undefined, no counter
// flops exist and both counter outputs are tied to zero.
//
// The FSM state is exposed on state_dbg with this encoding:
// RUN=0, DWAIT=1, DRAIN=2, REDIR=3.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  hazard_ctrl_if.slave   bus,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    DRAIN = 2'd2,
    REDIR = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic freeze_req;
  logic load_use;

  // A data access is outstanding and not completing this cycle.
  assign freeze_req = bus.dmem_req && !bus.dmem_resp;

  // The decode-stage instruction reads the register a load in execute writes.
  assign load_use = bus.id_ex_in_ld &&
                    ((bus.if_id_use_sr1 && (bus.if_id_sr1 == bus.id_ex_dr)) ||
                     (bus.if_id_use_sr2 && (bus.if_id_sr2 == bus.id_ex_dr)));

  assign state_dbg = state;

  // State register; reset forces RUN at once, independent of clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and pipeline controls; all controls are low during reset.
  always_comb begin
    state_next        = state;
    bus.load_pc       = 1'b0;
    bus.pc_sel_target = 1'b0;
    bus.load_if_id    = 1'b0;
    bus.load_id_ex    = 1'b0;
    bus.load_ex_mem   = 1'b0;
    bus.load_mem_wb   = 1'b0;
    bus.bubble_id_ex  = 1'b0;
    bus.flush         = 1'b0;

    if (!reset) begin
      unique case (state)
        RUN: begin
          if (freeze_req) begin
            // Whole pipeline holds; every enable stays low.
            state_next = DWAIT;
          end else if (bus.br_taken) begin
            // Front stages load NOPs and the datapath captures the target.
            // The PC waits for the in-flight fetch before redirecting.
            bus.flush       = 1'b1;
            bus.load_id_ex  = 1'b1;
            bus.load_ex_mem = 1'b1;
            bus.load_mem_wb = 1'b1;
            state_next      = bus.imem_resp ? REDIR : DRAIN;
          end else if (load_use || !bus.imem_resp) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX.
            bus.load_id_ex   = 1'b1;
            bus.load_ex_mem  = 1'b1;
            bus.load_mem_wb  = 1'b1;
            bus.bubble_id_ex = 1'b1;
          end else begin
            bus.load_pc     = 1'b1;
            bus.load_if_id  = 1'b1;
            bus.load_id_ex  = 1'b1;
            bus.load_ex_mem = 1'b1;
            bus.load_mem_wb = 1'b1;
          end
        end

        DWAIT: begin
          if (!freeze_req) begin
            // Access completes: the whole pipeline advances once.
            // A held branch is taken up in the following RUN cycle.
            bus.load_pc     = 1'b1;
            bus.load_if_id  = 1'b1;
            bus.load_id_ex  = 1'b1;
            bus.load_ex_mem = 1'b1;
            bus.load_mem_wb = 1'b1;
            state_next      = RUN;
          end
        end

        DRAIN: begin
          // Wait out the stale fetch; its word is discarded via load_if_id=0.
          bus.load_id_ex   = 1'b1;
          bus.load_ex_mem  = 1'b1;
          bus.load_mem_wb  = 1'b1;
          bus.bubble_id_ex = 1'b1;
          if (bus.imem_resp) begin
            state_next = REDIR;
          end
        end

        REDIR: begin
          // Single cycle that loads the held branch target into the PC.
          bus.load_pc       = 1'b1;
          bus.pc_sel_target = 1'b1;
          bus.load_id_ex    = 1'b1;
          bus.load_ex_mem   = 1'b1;
          bus.load_mem_wb   = 1'b1;
          bus.bubble_id_ex  = 1'b1;
          state_next        = RUN;
        end

        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] mem_cnt;
  logic             lu_inc;
  logic             mem_inc;

  // Only cycles where the hazard actually wins priority are counted.
  assign lu_inc  = (state == RUN) && !freeze_req && !bus.br_taken && load_use;
  assign mem_inc = ((state == RUN) || (state == DWAIT)) && freeze_req;

  // Saturating event counters, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lu_cnt  <= '0;
      mem_cnt <= '0;
    end else begin
      if (lu_inc && (lu_cnt != {CNT_W{1'b1}})) begin
        lu_cnt <= lu_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (mem_inc && (mem_cnt != {CNT_W{1'b1}})) begin
        mem_cnt <= mem_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.lu_stall_cnt  = lu_cnt;
  assign bus.mem_stall_cnt = mem_cnt;
`else
  logic [CNT_W-1:0] zero_cnt;

  assign zero_cnt          = '0;
  assign bus.lu_stall_cnt  = zero_cnt;
  assign bus.mem_stall_cnt = zero_cnt;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 CNT_W, 16, width of each performance counter.
REQ-002 clk  in  1  rising-edge clock; sole clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 if_id_sr1  in  3  SR1 of the decode-stage instruction.
REQ-005 if_id_sr2  in  3  SR2 of the decode-stage instruction.
REQ-006 if_id_use_sr1  in  1  decode-stage instruction reads SR1.
REQ-007 if_id_use_sr2  in  1  decode-stage instruction reads SR2.
REQ-008 id_ex_dr  in  3  DR of the execute-stage instruction.
REQ-009 id_ex_in_ld  in  1  execute-stage instruction is a load.
REQ-010 imem_resp  in  1  instruction fetch completes this cycle.
REQ-011 dmem_req  in  1  MEM-stage data access pending.
REQ-012 dmem_resp  in  1  data access completes this cycle.
REQ-013 br_taken  in  1  MEM-stage control transfer taken.
REQ-014 load_pc  out  1  PC register enable.
REQ-015 pc_sel_target  out  1  PC mux selects the held branch target.
REQ-016 load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  pipeline register enables.
REQ-017 bubble_id_ex  out  1  ID/EX loads a NOP.
REQ-018 flush  out  1  IF/ID, ID/EX and EX/MEM load NOPs; datapath captures branch target.
REQ-019 lu_stall_cnt  out  CNT_W  load-use bubble cycles.
REQ-020 mem_stall_cnt  out  CNT_W  data-memory freeze cycles.

Function
REQ-021 States: RUN, DWAIT, DRAIN, REDIR.
REQ-022 Outputs are combinational from state and inputs; default in RUN: all load_* = 1, other controls = 0.
REQ-023 Priority per cycle: data freeze > branch > load-use > fetch stall.
REQ-024 Freeze: (RUN or DWAIT) and dmem_req and !dmem_resp -> all load_* = 0, flush = 0, bubble_id_ex = 0; next state DWAIT.
REQ-025 DWAIT with dmem_resp = 1 -> all load_* = 1; next state RUN. br_taken is ignored during freeze cycles.
REQ-026 Branch: RUN, no freeze, br_taken = 1 -> flush = 1, load_pc = 0, load_if_id = 0; next state DRAIN if imem_resp = 0, else REDIR.
REQ-027 DRAIN: load_pc = 0, load_if_id = 0, bubble_id_ex = 1; on imem_resp = 1 discard the fetched word and go to REDIR.
REQ-028 REDIR: exactly one cycle with load_pc = 1, pc_sel_target = 1, load_if_id = 0, bubble_id_ex = 1; next state RUN.
REQ-029 Load-use: RUN, id_ex_in_ld and ((use_sr1 and sr1 == dr) or (use_sr2 and sr2 == dr)) -> load_pc = 0, load_if_id = 0, bubble_id_ex = 1 for one cycle.
REQ-030 Fetch stall: RUN, imem_resp = 0, no higher-priority event -> load_pc = 0, load_if_id = 0, bubble_id_ex = 1.
REQ-031 Counters increment by 1 per qualifying cycle (REQ-029, REQ-024) and saturate at all-ones.

Reset
REQ-032 reset = 1 -> state RUN and counters 0 immediately, regardless of clk or current state.
REQ-033 While reset = 1, all load_*, flush, bubble_id_ex and pc_sel_target = 0.

Configuration
REQ-034 HAZARD_CTRL_PERF_EN defined -> both counters are implemented per REQ-031.
REQ-035 HAZARD_CTRL_PERF_EN undefined -> no counter flops are built; lu_stall_cnt and mem_stall_cnt are constant 0.

Verification
REQ-036 id_ex_in_ld = 1, id_ex_dr = 3, if_id_sr1 = 3, use_sr1 = 1 -> one cycle load_pc = 0, load_if_id = 0, bubble_id_ex = 1; lu_stall_cnt 0 -> 1.
REQ-037 dmem_req = 1, dmem_resp low 3 cycles then high -> all load_* = 0 for 3 cycles, all = 1 on cycle 4; mem_stall_cnt = 3.
REQ-038 br_taken = 1 with imem_resp low 2 more cycles -> flush 1 cycle, DRAIN, REDIR 1 cycle with pc_sel_target = 1, then RUN.
REQ-039 br_taken = 1 during a freeze -> flush = 0 until dmem_resp = 1; flush asserts the following cycle only if br_taken is still held.
REQ-040 reset pulse while in DRAIN -> state RUN and counters 0 without a clk edge; CNT_W = 4 with 20 load-use cycles -> lu_stall_cnt = 15.
